// File: rtl/vision_apb3_router.sv
// =============================================================================
// vision_apb3_router : APB3 1-to-N address-decoding router with timeout/errors
// Revision 1.0
// =============================================================================
`default_nettype none

module vision_apb3_router #(
  parameter int NUM_SLAVES      = 3,
  parameter int APB3_ADDR_WIDTH = 16,
  parameter int APB3_DATA_WIDTH = 32,
  parameter int SEL_LSB         = 12,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                                  io_peripheralClk,
  input  logic                                  io_peripheralReset,
  input  logic [APB3_ADDR_WIDTH-1:0]            s_PADDR,
  input  logic                                  s_PSEL,
  input  logic                                  s_PENABLE,
  input  logic                                  s_PWRITE,
  input  logic [APB3_DATA_WIDTH-1:0]            s_PWDATA,
  output logic                                  s_PREADY,
  output logic [APB3_DATA_WIDTH-1:0]            s_PRDATA,
  output logic                                  s_PSLVERROR,
  output logic [APB3_ADDR_WIDTH-1:0]            m_PADDR,
  output logic [NUM_SLAVES-1:0]                 m_PSEL,
  output logic                                  m_PENABLE,
  output logic                                  m_PWRITE,
  output logic [APB3_DATA_WIDTH-1:0]            m_PWDATA,
  input  logic [NUM_SLAVES*APB3_DATA_WIDTH-1:0] m_PRDATA,
  input  logic [NUM_SLAVES-1:0]                 m_PREADY,
  input  logic [NUM_SLAVES-1:0]                 m_PSLVERROR,
  input  logic                                  i_err_clr,
  output logic [15:0]                           o_timeout_cnt,
  output logic [15:0]                           o_decerr_cnt,
  output logic [3:0]                            o_last_err_idx
);

  localparam int DW = APB3_DATA_WIDTH;
  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TLIM = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [IW:0] NS = (IW + 1)'(NUM_SLAVES);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RESP, DRAIN} state_t;

  state_t                      state_q, state_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [TW-1:0]               timer_q, timer_d;
  logic [APB3_ADDR_WIDTH-1:0]  paddr_q, paddr_d;
  logic                        pwrite_q, pwrite_d;
  logic [DW-1:0]               pwdata_q, pwdata_d;
  logic [NUM_SLAVES-1:0]       psel_q, psel_d;
  logic                        penable_q, penable_d;
  logic                        pready_q, pready_d;
  logic [DW-1:0]               prdata_q, prdata_d;
  logic                        pslverr_q, pslverr_d;
  logic [15:0]                 timeout_cnt_q, timeout_cnt_d;
  logic [15:0]                 decerr_cnt_q, decerr_cnt_d;
  logic [3:0]                  last_idx_q, last_idx_d;

  logic [IW-1:0]               w_idx;
  logic                        w_hit;
  logic                        sel_ready, sel_err, tmo_hit, inc_tmo, inc_dec, to_resp;
  logic [DW-1:0]               sel_rdata;

  assign w_idx = s_PADDR[SEL_LSB +: IW];
  assign w_hit = ({1'b0, w_idx} < NS);
  assign tmo_hit = TMO_EN && (timer_q == TLIM);

  // Only the addressed slave's ready/error/data are ever looked at.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IW'(i)) begin
        sel_ready = m_PREADY[i];
        sel_err   = m_PSLVERROR[i];
        sel_rdata = m_PRDATA[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    timer_d       = timer_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pready_d      = 1'b0;
    prdata_d      = prdata_q;
    pslverr_d     = pslverr_q;
    timeout_cnt_d = timeout_cnt_q;
    decerr_cnt_d  = decerr_cnt_q;
    last_idx_d    = last_idx_q;
    inc_tmo       = 1'b0;
    inc_dec       = 1'b0;
    to_resp       = (state_q == ACCESS) && s_PSEL;
    psel_d        = '0;
    penable_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_PSEL && !s_PENABLE) begin
          paddr_d  = s_PADDR;
          pwrite_d = s_PWRITE;
          pwdata_d = s_PWDATA;
          idx_d    = w_idx;
          timer_d  = '0;
          if (w_hit) begin
            state_d = SETUP;
          end else begin
            // Decode miss: RESP first idles one cycle before raising ready.
            state_d    = RESP;
            prdata_d   = '0;
            pslverr_d  = 1'b1;
            inc_dec    = 1'b1;
            last_idx_d = 4'(w_idx);
          end
        end
      end
      SETUP: state_d = s_PSEL ? ACCESS : DRAIN;
      ACCESS, DRAIN: begin
        timer_d = timer_q + TW'(1);
        if (sel_ready) begin
          state_d = to_resp ? RESP : IDLE;
          if (to_resp) begin
            pready_d  = 1'b1;
            prdata_d  = (pwrite_q || sel_err) ? '0 : sel_rdata;
            pslverr_d = sel_err;
            if (sel_err) last_idx_d = 4'(idx_q);
          end
        end else if (tmo_hit) begin
          state_d    = to_resp ? RESP : IDLE;
          inc_tmo    = 1'b1;
          last_idx_d = 4'(idx_q);
          if (to_resp) begin
            pready_d  = 1'b1;
            prdata_d  = '0;
            pslverr_d = 1'b1;
          end
        end else if (state_q == ACCESS && !s_PSEL) begin
          state_d = DRAIN;
        end
      end
      RESP: begin
        if (pready_q) state_d = IDLE;
        else          pready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (i_err_clr) begin
      timeout_cnt_d = '0;
      decerr_cnt_d  = '0;
      last_idx_d    = '0;
    end else begin
      if (inc_tmo && timeout_cnt_q != 16'hFFFF) timeout_cnt_d = timeout_cnt_q + 16'd1;
      if (inc_dec && decerr_cnt_q != 16'hFFFF)  decerr_cnt_d  = decerr_cnt_q + 16'd1;
    end

    // Downstream strobes are registered from the next state so they track it.
    if (state_d inside {SETUP, ACCESS, DRAIN}) begin
      for (int i = 0; i < NUM_SLAVES; i++) psel_d[i] = (idx_d == IW'(i));
    end
    penable_d = (state_d inside {ACCESS, DRAIN});
  end

  always_ff @(posedge io_peripheralClk or posedge io_peripheralReset) begin
    if (io_peripheralReset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      timer_q       <= '0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      pready_q      <= 1'b0;
      prdata_q      <= '0;
      pslverr_q     <= 1'b0;
      timeout_cnt_q <= '0;
      decerr_cnt_q  <= '0;
      last_idx_q    <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pready_q      <= pready_d;
      prdata_q      <= prdata_d;
      pslverr_q     <= pslverr_d;
      timeout_cnt_q <= timeout_cnt_d;
      decerr_cnt_q  <= decerr_cnt_d;
      last_idx_q    <= last_idx_d;
    end
  end

  assign s_PREADY       = pready_q;
  assign s_PRDATA       = prdata_q;
  assign s_PSLVERROR    = pslverr_q;
  assign m_PADDR        = paddr_q;
  assign m_PSEL         = psel_q;
  assign m_PENABLE      = penable_q;
  assign m_PWRITE       = pwrite_q;
  assign m_PWDATA       = pwdata_q;
  assign o_timeout_cnt  = timeout_cnt_q;
  assign o_decerr_cnt   = decerr_cnt_q;
  assign o_last_err_idx = last_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_vision_apb3_router.sv
// =============================================================================
// tb_vision_apb3_router : scoreboard bench for the APB3 router
// Revision 1.0
// =============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vision_apb3_router;
  localparam int NS = 3;
  localparam int AW = 16;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [AW-1:0]    s_PADDR = '0;
  logic             s_PSEL = 1'b0, s_PENABLE = 1'b0, s_PWRITE = 1'b0;
  logic [DW-1:0]    s_PWDATA = '0;
  logic             s_PREADY, s_PSLVERROR;
  logic [DW-1:0]    s_PRDATA;
  logic [AW-1:0]    m_PADDR;
  logic [NS-1:0]    m_PSEL;
  logic             m_PENABLE, m_PWRITE;
  logic [DW-1:0]    m_PWDATA;
  logic [NS*DW-1:0] m_PRDATA = {32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
  logic [NS-1:0]    m_PREADY = '0;
  logic [NS-1:0]    m_PSLVERROR = '0;
  logic             i_err_clr = 1'b0;
  logic [15:0]      o_timeout_cnt, o_decerr_cnt;
  logic [3:0]       o_last_err_idx;

  always #5 clk = ~clk;

  vision_apb3_router #(
    .NUM_SLAVES(NS), .APB3_ADDR_WIDTH(AW), .APB3_DATA_WIDTH(DW),
    .SEL_LSB(12), .TIMEOUT_CYCLES(8)
  ) dut (
    .io_peripheralClk(clk), .io_peripheralReset(rst),
    .s_PADDR(s_PADDR), .s_PSEL(s_PSEL), .s_PENABLE(s_PENABLE), .s_PWRITE(s_PWRITE),
    .s_PWDATA(s_PWDATA), .s_PREADY(s_PREADY), .s_PRDATA(s_PRDATA), .s_PSLVERROR(s_PSLVERROR),
    .m_PADDR(m_PADDR), .m_PSEL(m_PSEL), .m_PENABLE(m_PENABLE), .m_PWRITE(m_PWRITE),
    .m_PWDATA(m_PWDATA), .m_PRDATA(m_PRDATA), .m_PREADY(m_PREADY), .m_PSLVERROR(m_PSLVERROR),
    .i_err_clr(i_err_clr), .o_timeout_cnt(o_timeout_cnt), .o_decerr_cnt(o_decerr_cnt),
    .o_last_err_idx(o_last_err_idx)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   dly[NS] = '{0, 0, 0};
  int   acnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave model: addressed slave readies after dly[i] ACCESS cycles; others idle with ready high.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NS; i++)
      m_PREADY[i] = (m_PSEL[i] && m_PENABLE) ? (acnt == dly[i]) : 1'b1;
    acnt = (m_PENABLE && m_PSEL != '0) ? acnt + 1 : 0;
  end

  // Monitor: every s_PREADY pulse must match the oldest expected response.
  initial forever begin
    @(negedge clk);
    if (!rst && s_PREADY) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pready: got s_PREADY=1 at cycle %0d expected no response", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("s_PRDATA", s_PRDATA, e.rdata);
        chk("s_PSLVERROR", {31'd0, s_PSLVERROR}, {31'd0, e.err});
        chk("pready_cycle", cyc, e.due);
      end
    end
  end

  // mode 0: normal, 1: master abort in ACCESS, 2: stray setup in ACCESS, 3: reset in ACCESS
  task automatic xfer(input logic [15:0] addr, input logic wr, input logic [31:0] wd,
                      input logic [2:0] exp_sel, input logic [31:0] exp_rd, input logic exp_err,
                      input int lat, input int mode);
    int k;
    int n;
    @(negedge clk);
    k = cyc;
    s_PADDR = addr; s_PWRITE = wr; s_PWDATA = wd; s_PSEL = 1'b1; s_PENABLE = 1'b0;
    if (mode == 0 || mode == 2) sbq.push_back('{exp_rd, exp_err, k + lat});
    @(negedge clk);
    s_PENABLE = 1'b1;
    chk("m_PSEL_setup", {29'd0, m_PSEL}, {29'd0, exp_sel});
    chk("m_PENABLE_setup", {31'd0, m_PENABLE}, 32'd0);
    chk("m_PADDR", {16'd0, m_PADDR}, {16'd0, addr});
    chk("m_PWRITE", {31'd0, m_PWRITE}, {31'd0, wr});
    chk("m_PWDATA", m_PWDATA, wd);
    if (mode == 1) begin
      @(negedge clk);
      s_PSEL = 1'b0; s_PENABLE = 1'b0;
      @(negedge clk);
      chk("drain_psel_a", {29'd0, m_PSEL}, {29'd0, exp_sel});
      chk("drain_penable", {31'd0, m_PENABLE}, 32'd1);
      @(negedge clk);
      chk("drain_psel_b", {29'd0, m_PSEL}, {29'd0, exp_sel});
      @(negedge clk);
      chk("drain_done_psel", {29'd0, m_PSEL}, 32'd0);
      repeat (2) @(negedge clk);
    end else if (mode == 3) begin
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst_m_PSEL", {29'd0, m_PSEL}, 32'd0);
      chk("rst_m_PENABLE", {31'd0, m_PENABLE}, 32'd0);
      chk("rst_s_PREADY", {31'd0, s_PREADY}, 32'd0);
      chk("rst_timeout_cnt", {16'd0, o_timeout_cnt}, 32'd0);
      chk("rst_decerr_cnt", {16'd0, o_decerr_cnt}, 32'd0);
      s_PSEL = 1'b0; s_PENABLE = 1'b0;
      @(negedge clk);
      rst = 1'b0;
    end else begin
      if (mode == 2) begin
        @(negedge clk);
        s_PENABLE = 1'b0; s_PADDR = 16'h2000; s_PWRITE = 1'b1;
        @(negedge clk);
        s_PENABLE = 1'b1; s_PADDR = addr; s_PWRITE = wr;
      end
      n = 0;
      while (!s_PREADY && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (n >= 40) begin
        total++;
        bad++;
        $display("FAIL wait_pready: got no s_PREADY within 40 cycles expected one at cycle %0d", k + lat);
      end
      @(negedge clk);
      s_PSEL = 1'b0; s_PENABLE = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion before 200us");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_s_PREADY", {31'd0, s_PREADY}, 32'd0);
    chk("reset_s_PRDATA", s_PRDATA, 32'd0);
    chk("reset_s_PSLVERROR", {31'd0, s_PSLVERROR}, 32'd0);
    chk("reset_m_PSEL", {29'd0, m_PSEL}, 32'd0);
    chk("reset_m_PENABLE", {31'd0, m_PENABLE}, 32'd0);
    chk("reset_counters", {o_timeout_cnt, o_decerr_cnt}, 32'd0);
    chk("reset_last_idx", {28'd0, o_last_err_idx}, 32'd0);
    rst = 1'b0;

    xfer(16'h1004, 1'b0, 32'h0, 3'b010, 32'hCAFE0001, 1'b0, 3, 0);
    xfer(16'h0010, 1'b1, 32'h55, 3'b001, 32'h0, 1'b0, 3, 0);
    dly[2] = 1;
    xfer(16'h2008, 1'b0, 32'h0, 3'b100, 32'hCAFE0002, 1'b0, 4, 0);

    m_PSLVERROR = 3'b010;
    xfer(16'h1000, 1'b0, 32'h0, 3'b010, 32'h0, 1'b1, 3, 0);
    m_PSLVERROR = 3'b000;
    chk("slverr_last_idx", {28'd0, o_last_err_idx}, 32'd1);
    chk("slverr_counters", {o_timeout_cnt, o_decerr_cnt}, 32'd0);

    xfer(16'h3000, 1'b1, 32'h3C, 3'b000, 32'h0, 1'b1, 2, 0);
    chk("decerr_cnt", {16'd0, o_decerr_cnt}, 32'd1);
    chk("decerr_tmo_cnt", {16'd0, o_timeout_cnt}, 32'd0);

    dly[2] = 255;
    xfer(16'h2000, 1'b0, 32'h0, 3'b100, 32'h0, 1'b1, 10, 0);
    chk("tmo_cnt", {16'd0, o_timeout_cnt}, 32'd1);
    chk("tmo_last_idx", {28'd0, o_last_err_idx}, 32'd2);
    chk("tmo_decerr_cnt", {16'd0, o_decerr_cnt}, 32'd1);

    dly[1] = 2;
    xfer(16'h1004, 1'b0, 32'h0, 3'b010, 32'h0, 1'b0, 0, 1);
    dly[1] = 0;
    xfer(16'h1008, 1'b0, 32'h0, 3'b010, 32'hCAFE0001, 1'b0, 3, 0);

    dly[1] = 3;
    xfer(16'h1004, 1'b0, 32'h0, 3'b010, 32'hCAFE0001, 1'b0, 6, 2);

    dly[1] = 5;
    xfer(16'h1004, 1'b0, 32'h0, 3'b010, 32'h0, 1'b0, 0, 3);
    dly[1] = 0;
    xfer(16'h1004, 1'b0, 32'h0, 3'b010, 32'hCAFE0001, 1'b0, 3, 0);

    @(negedge clk);
    force dut.timeout_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.timeout_cnt_q;
    chk("sat_preload", {16'd0, o_timeout_cnt}, 32'h0000FFFF);
    dly[2] = 255;
    xfer(16'h2000, 1'b0, 32'h0, 3'b100, 32'h0, 1'b1, 10, 0);
    chk("sat_hold", {16'd0, o_timeout_cnt}, 32'h0000FFFF);

    fork
      xfer(16'h2000, 1'b0, 32'h0, 3'b100, 32'h0, 1'b1, 10, 0);
      begin
        repeat (10) @(negedge clk);
        i_err_clr = 1'b1;
        @(negedge clk);
        i_err_clr = 1'b0;
      end
    join
    chk("clr_wins_tmo_cnt", {16'd0, o_timeout_cnt}, 32'd0);
    chk("clr_wins_last_idx", {28'd0, o_last_err_idx}, 32'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vision_apb3_router.md
VISION_APB3_ROUTER -- requirements
Module: vision_apb3_router

Interface
REQ-001 The parameter NUM_SLAVES SHALL default to 3 and set the number of downstream APB3 slaves (legal range 1..16).
REQ-002 The parameter APB3_ADDR_WIDTH SHALL default to 16 and set the address width.
REQ-003 The parameter APB3_DATA_WIDTH SHALL default to 32 and set the data width.
REQ-004 The parameter SEL_LSB SHALL default to 12 and set the low bit of the slave-index field; the field is PADDR[SEL_LSB +: clog2(NUM_SLAVES)], at least 1 bit wide.
REQ-005 The parameter TIMEOUT_CYCLES SHALL default to 255 and set the ACCESS-cycle limit; a value of 0 disables the timeout.
REQ-006 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-007 The ports SHALL be as follows, clock and reset first:
io_peripheralClk  in  1  clock.
io_peripheralReset  in  1  asynchronous, active-high reset.
s_PADDR  in  AW  master address.
s_PSEL  in  1  master select.
s_PENABLE  in  1  master enable.
s_PWRITE  in  1  master write.
s_PWDATA  in  DW  master write data.
s_PREADY  out  1  master ready.
s_PRDATA  out  DW  master read data.
s_PSLVERROR  out  1  master error.
m_PADDR  out  AW  slave address (shared).
m_PSEL  out  NUM_SLAVES  one-hot slave select.
m_PENABLE  out  1  slave enable (shared).
m_PWRITE  out  1  slave write (shared).
m_PWDATA  out  DW  slave write data (shared).
m_PRDATA  in  NUM_SLAVES*DW  slave read data; slave i occupies [i*DW +: DW].
m_PREADY  in  NUM_SLAVES  slave ready.
m_PSLVERROR  in  NUM_SLAVES  slave error.
i_err_clr  in  1  clears the error statistics.
o_timeout_cnt  out  16  saturating count of timeouts.
o_decerr_cnt  out  16  saturating count of unmapped accesses.
o_last_err_idx  out  4  slave index of the most recent error.

Function
REQ-008 The FSM SHALL have five states (IDLE, SETUP, ACCESS, RESP, DRAIN), and every output SHALL be registered.
REQ-009 In IDLE, when s_PSEL=1 and s_PENABLE=0, the block SHALL latch s_PADDR, s_PWRITE and s_PWDATA and compute idx.
REQ-010 If idx < NUM_SLAVES on that IDLE cycle, the FSM SHALL go to SETUP; otherwise it SHALL go to RESP with error=1 and o_decerr_cnt incremented.
REQ-011 In SETUP the block SHALL drive m_PSEL[idx]=1 and m_PENABLE=0, then go to ACCESS.
REQ-012 In ACCESS the block SHALL drive m_PSEL[idx]=1 and m_PENABLE=1, and the timer SHALL increment every cycle.
REQ-013 When m_PREADY[idx]=1 in ACCESS, the block SHALL capture m_PRDATA slice idx and m_PSLVERROR[idx], drop m_PSEL/m_PENABLE, and go to RESP.
REQ-014 When the timer reaches TIMEOUT_CYCLES (nonzero) with no ready, the block SHALL drop m_PSEL/m_PENABLE, go to RESP with error=1 and data 0, increment o_timeout_cnt, and set o_last_err_idx=idx.
REQ-015 In RESP the block SHALL drive s_PREADY=1 for exactly one cycle, with s_PRDATA=captured data (0 for writes and errors) and s_PSLVERROR=error, then go to IDLE.
REQ-016 s_PREADY SHALL be 0 in every state other than RESP.
REQ-017 Minimum latency SHALL be: master setup at cycle N gives s_PREADY=1 at N+3 when the slave is ready on its first ACCESS cycle.
REQ-018 If s_PSEL falls during SETUP or ACCESS (master abort), the FSM SHALL go to DRAIN, which completes or times out the downstream transfer, discards the response, and returns to IDLE without asserting s_PREADY.
REQ-019 m_PREADY of non-selected slaves SHALL be ignored.
REQ-020 A slave PSLVERROR SHALL update o_last_err_idx but SHALL NOT increment either counter.
REQ-021 Both counters SHALL saturate at 16'hFFFF.
REQ-022 i_err_clr SHALL zero both counters and o_last_err_idx, and on a clear coinciding with an increment the clear SHALL win.
REQ-023 A new master setup phase while not in IDLE SHALL NOT be accepted and SHALL NOT disturb the transfer in progress.

Reset
REQ-024 While io_peripheralReset=1, including mid-transfer, the FSM SHALL be in IDLE; all outputs, the timer, both counters and o_last_err_idx SHALL be 0; and m_PSEL SHALL be all-zero.

Verification
REQ-025 Read of slave 1 at 0x1004 with the slave ready on its first ACCESS cycle and PRDATA=0xCAFE0001 -> m_PSEL=3'b010, s_PREADY at setup+3, s_PRDATA=0xCAFE0001, s_PSLVERROR=0.
REQ-026 Write of 0x3C to 0x3000 (idx 3, NUM_SLAVES=3) -> no m_PSEL activity, s_PREADY=1 with s_PSLVERROR=1 at setup+2, o_decerr_cnt=1.
REQ-027 Slave 2 never asserts ready, TIMEOUT_CYCLES=8 -> m_PSEL[2] deasserts after 8 ACCESS cycles, then s_PSLVERROR=1, s_PRDATA=0, o_timeout_cnt=1, o_last_err_idx=2.
REQ-028 s_PSEL dropped during ACCESS, slave ready 2 cycles later -> no s_PREADY pulse, FSM back in IDLE, and the next read completes normally.
REQ-029 Reset pulsed during ACCESS -> m_PSEL=0, s_PREADY=0 and counters 0 on the same edge; the first transfer after reset completes normally.
REQ-030 0xFFFF timeouts followed by one more -> o_timeout_cnt stays 0xFFFF; i_err_clr pulsed together with a timeout -> 0.
